// File: rtl/cpu_pkg.sv
// cpu_pkg: shared arbiter state/grant types and Wishbone constants
package cpu_pkg;
  typedef enum logic [1:0] {IDLE, BUS_INS, BUS_MEM} arb_state_t;
  typedef enum logic {GNT_INS, GNT_MEM} grant_t;
  localparam logic [3:0] WB_SEL_ALL = 4'hF;
endpackage

// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: Wishbone B4 classic bus between the CPU arbiter and the bus slave
interface wb_arbiter_if;
  logic [31:0] dat_i;
  logic        ack_i;
  logic [31:0] dat_o;
  logic [29:0] adr_o;
  logic        cyc_o;
  logic        stb_o;
  logic [3:0]  sel_o;
  logic        we_o;
  modport master (input dat_i, ack_i, output dat_o, adr_o, cyc_o, stb_o, sel_o, we_o);
  modport slave (output dat_i, ack_i, input dat_o, adr_o, cyc_o, stb_o, sel_o, we_o);
endinterface

// File: rtl/wb_lane.sv
// wb_lane: byte-lane steering between an 8-bit data port and the 32-bit bus
module wb_lane (
  input  logic [1:0]  lane_i,
  input  logic [7:0]  wbyte_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  sel_o,
  output logic [31:0] wword_o,
  output logic [7:0]  rbyte_o
);
  // One-hot select for the lane, store byte replicated on every lane, load byte picked from the lane
  always_comb begin
    sel_o   = 4'b0001 << lane_i;
    wword_o = {4{wbyte_i}};
    rbyte_o = rword_i[{lane_i, 3'b000} +: 8];
  end
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin sharing of one Wishbone classic master between fetch and load/store
module wb_arbiter
  import cpu_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic        ins_en,
  input  logic [29:0] ins_addr,
  output logic        ins_stl,
  output logic        ins_ack,
  output logic        ins_err,
  output logic [31:0] ins_data,
  input  logic        mem_en,
  input  logic [31:0] mem_addr,
  input  logic        mem_we,
  input  logic [7:0]  mem_data_i,
  output logic        mem_stl,
  output logic        mem_ack,
  output logic        mem_err,
  output logic [7:0]  mem_data_o,
  wb_arbiter_if.master wb
);
  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam int TM = (TIMEOUT < 1) ? 0 : TIMEOUT - 1;

  arb_state_t    state_q, state_d;
  grant_t        last_q, last_d;
  logic          cyc_q, cyc_d;
  logic          we_q, we_d;
  logic [3:0]    sel_q, sel_d;
  logic [29:0]   adr_q, adr_d;
  logic [31:0]   dat_q, dat_d;
  logic [1:0]    lane_q, lane_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    lane_idx;
  logic [3:0]    lane_sel;
  logic [31:0]   lane_wword;
  logic [7:0]    lane_rbyte;
  logic          pick_mem;
  logic          to_hit;
  logic          done;

  // Before a grant the lane comes from the live address; during the cycle from the latched one
  assign lane_idx = (state_q == BUS_MEM) ? lane_q : mem_addr[1:0];

  wb_lane u_lane (
    .lane_i  (lane_idx),
    .wbyte_i (mem_data_i),
    .rword_i (wb.dat_i),
    .sel_o   (lane_sel),
    .wword_o (lane_wword),
    .rbyte_o (lane_rbyte)
  );

  assign pick_mem   = mem_en & (~ins_en | (last_q == GNT_INS));
  assign to_hit     = (TIMEOUT != 0) && (cnt_q == CW'(TM));
  assign done       = wb.ack_i | to_hit;
  assign ins_ack    = (state_q == BUS_INS) & wb.ack_i;
  assign ins_err    = (state_q == BUS_INS) & ~wb.ack_i & to_hit;
  assign mem_ack    = (state_q == BUS_MEM) & wb.ack_i;
  assign mem_err    = (state_q == BUS_MEM) & ~wb.ack_i & to_hit;
  assign ins_stl    = ins_en & ~ins_ack & ~ins_err;
  assign mem_stl    = mem_en & ~mem_ack & ~mem_err;
  assign ins_data   = wb.dat_i;
  assign mem_data_o = lane_rbyte;
  assign wb.cyc_o   = cyc_q;
  assign wb.stb_o   = cyc_q;
  assign wb.we_o    = we_q;
  assign wb.sel_o   = sel_q;
  assign wb.adr_o   = adr_q;
  assign wb.dat_o   = dat_q;

  // Arbiter state, grant history, timeout counter and registered bus outputs
  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      state_q <= IDLE;
      last_q  <= GNT_INS;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      lane_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      lane_q  <= lane_d;
      cnt_q   <= cnt_d;
    end
  end

  // Grant and load the bus in IDLE; close the cycle on ack or timeout, otherwise count the wait
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    sel_d   = sel_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    lane_d  = lane_q;
    cnt_d   = cnt_q;
    if (state_q == IDLE) begin
      if (ins_en | mem_en) begin
        state_d = pick_mem ? BUS_MEM : BUS_INS;
        last_d  = pick_mem ? GNT_MEM : GNT_INS;
        cyc_d   = 1'b1;
        we_d    = pick_mem & mem_we;
        sel_d   = pick_mem ? lane_sel : WB_SEL_ALL;
        adr_d   = pick_mem ? mem_addr[31:2] : ins_addr;
        dat_d   = pick_mem ? lane_wword : '0;
        lane_d  = mem_addr[1:0];
        cnt_d   = '0;
      end
    end else if (done) begin
      state_d = IDLE;
      cyc_d   = 1'b0;
      we_d    = 1'b0;
      sel_d   = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: randomized scoreboard bench for the Wishbone arbiter
module tb_wb_arbiter;
  import cpu_pkg::*;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ins_en = 1'b0;
  logic [29:0] ins_addr = '0;
  logic        ins_stl, ins_ack, ins_err;
  logic [31:0] ins_data;
  logic        mem_en = 1'b0;
  logic [31:0] mem_addr = '0;
  logic        mem_we = 1'b0;
  logic [7:0]  mem_data_i = '0;
  logic        mem_stl, mem_ack, mem_err;
  logic [7:0]  mem_data_o;

  wb_arbiter_if wb ();

  always #5 clk = ~clk;

  wb_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .cpu_clk    (clk),
    .cpu_rst    (rst_n),
    .ins_en     (ins_en),
    .ins_addr   (ins_addr),
    .ins_stl    (ins_stl),
    .ins_ack    (ins_ack),
    .ins_err    (ins_err),
    .ins_data   (ins_data),
    .mem_en     (mem_en),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_data_i (mem_data_i),
    .mem_stl    (mem_stl),
    .mem_ack    (mem_ack),
    .mem_err    (mem_err),
    .mem_data_o (mem_data_o),
    .wb         (wb)
  );

  typedef struct {
    logic        err;
    logic        rd;
    logic [31:0] data;
    logic [29:0] adr;
    logic [3:0]  sel;
    logic        we;
    logic [31:0] dat;
  } exp_t;

  exp_t ins_q[$];
  exp_t mem_q[$];
  int   order_q[$];
  int   checks = 0;
  int   fails = 0;
  bit   chk_order = 1'b0;
  int   last_cyc = -1;
  int   force_delay = -1;
  int   max_delay = 15;
  int   cyc_n = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic miss(input string name);
    checks++;
    fails++;
    $display("FAIL %s: got nothing expected completion", name);
  endtask

  // slave memory image: two fixed words, every other word a function of its address
  function automatic logic [31:0] rd_word(input logic [29:0] a);
    return (a == 30'h100) ? 32'hDEADBEEF : (a == 30'h200) ? 32'h11223344 : {a[15:0] ^ 16'hC3A5, a[29:14]};
  endfunction

  // addresses in the top region never acknowledge
  function automatic logic hang(input logic [29:0] a);
    return a[29:24] == 6'h3F;
  endfunction

  // bus slave: per-cycle ack delay, junk data when not acking, stray acks while idle
  initial begin
    int age;
    int d;
    age = 0;
    d = 0;
    wb.ack_i = 1'b0;
    wb.dat_i = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n || !wb.cyc_o) begin
        age = 0;
        wb.ack_i = rst_n && ($urandom_range(0, 9) == 0);
        wb.dat_i = $urandom;
      end else begin
        if (age == 0)
          d = hang(wb.adr_o) ? 1000 : (force_delay >= 0) ? force_delay :
              ($urandom_range(0, 3) == 0) ? 15 : int'($urandom_range(0, max_delay));
        age++;
        wb.ack_i = (age == d + 1);
        wb.dat_i = wb.ack_i ? rd_word(wb.adr_o) : $urandom;
      end
    end
  end

  task automatic cmp(input string who, input exp_t e, input logic err, input logic [31:0] data, input int age);
    chk({who, "_err"}, 32'(err), 32'(e.err));
    chk({who, "_adr"}, 32'(wb.adr_o), 32'(e.adr));
    chk({who, "_sel"}, 32'(wb.sel_o), 32'(e.sel));
    chk({who, "_we"}, 32'(wb.we_o), 32'(e.we));
    chk({who, "_dat_o"}, wb.dat_o, e.dat);
    chk({who, "_stb"}, 32'(wb.stb_o), 32'd1);
    if (e.err) chk({who, "_timeout_cycle"}, 32'(age), 32'(TIMEOUT));
    else if (e.rd) chk({who, "_rdata"}, data, e.data);
  endtask

  task automatic order_chk(input int who);
    if (chk_order) begin
      if (order_q.size() == 0) miss("grant_order_extra");
      else chk("grant_order", 32'(who), 32'(order_q.pop_front()));
      if (last_cyc >= 0) chk("txn_spacing", 32'(cyc_n - last_cyc), 32'd2);
      last_cyc = cyc_n;
    end
  endtask

  // monitor: pops the expected response whenever a requester sees ack or err
  initial begin
    int age;
    bit prev;
    age = 0;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      cyc_n++;
      if (!rst_n) begin
        age = 0;
        prev = 1'b0;
      end else begin
        age = wb.cyc_o ? age + 1 : 0;
        if (prev) chk("bus_released", 32'(wb.cyc_o), 32'd0);
        chk("ins_stl", 32'(ins_stl), 32'(ins_en & ~ins_ack & ~ins_err));
        chk("mem_stl", 32'(mem_stl), 32'(mem_en & ~mem_ack & ~mem_err));
        prev = ins_ack | ins_err | mem_ack | mem_err;
        if (ins_ack | ins_err) begin
          if (ins_q.size() == 0) miss("ins_unexpected_strobe_none_queued");
          else cmp("ins", ins_q.pop_front(), ins_err, ins_data, age);
          order_chk(0);
        end
        if (mem_ack | mem_err) begin
          if (mem_q.size() == 0) miss("mem_unexpected_strobe_none_queued");
          else cmp("mem", mem_q.pop_front(), mem_err, 32'(mem_data_o), age);
          order_chk(1);
        end
      end
    end
  end

  task automatic ins_txn(input logic [29:0] a);
    exp_t e;
    bit done;
    done = 1'b0;
    e.err = hang(a);
    e.rd = 1'b1;
    e.data = rd_word(a);
    e.adr = a;
    e.sel = 4'hF;
    e.we = 1'b0;
    e.dat = '0;
    ins_q.push_back(e);
    ins_en = 1'b1;
    ins_addr = a;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      if (ins_ack || ins_err) done = 1'b1;
      else begin
        @(posedge clk);
        #1;
        if (wb.cyc_o && wb.sel_o == 4'hF) ins_addr = 30'($urandom);
      end
    end
    if (!done) miss("ins_completion_wait");
    @(posedge clk);
    #1;
    ins_en = 1'b0;
  endtask

  task automatic mem_txn(input logic [31:0] a, input logic w, input logic [7:0] d);
    exp_t e;
    bit done;
    done = 1'b0;
    e.err = hang(a[31:2]);
    e.rd = !w;
    e.data = (rd_word(a[31:2]) >> (8 * a[1:0])) & 32'hFF;
    e.adr = a[31:2];
    e.sel = 4'(1 << a[1:0]);
    e.we = w;
    e.dat = 32'(d) * 32'h01010101;
    mem_q.push_back(e);
    mem_en = 1'b1;
    mem_addr = a;
    mem_we = w;
    mem_data_i = d;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      if (mem_ack || mem_err) done = 1'b1;
      else begin
        @(posedge clk);
        #1;
        if (wb.cyc_o && wb.sel_o != 4'hF) begin
          mem_addr = $urandom;
          mem_we = 1'($urandom);
          mem_data_i = 8'($urandom);
        end
      end
    end
    if (!done) miss("mem_completion_wait");
    @(posedge clk);
    #1;
    mem_en = 1'b0;
  endtask

  task automatic ins_rand(input int n);
    logic [29:0] a;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
      a = 30'($urandom);
      if ($urandom_range(0, 7) == 0) a[29:24] = 6'h3F;
      else a[29] = 1'b0;
      ins_txn(a);
    end
  endtask

  task automatic mem_rand(input int n);
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
      a = $urandom;
      if ($urandom_range(0, 7) == 0) a[31:26] = 6'h3F;
      else a[31] = 1'b0;
      mem_txn(a, 1'($urandom), 8'($urandom));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cyc", 32'(wb.cyc_o), 32'd0);
    chk("rst_stb", 32'(wb.stb_o), 32'd0);
    chk("rst_we", 32'(wb.we_o), 32'd0);
    chk("rst_sel", 32'(wb.sel_o), 32'd0);
    chk("rst_adr", 32'(wb.adr_o), 32'd0);
    chk("rst_dat", wb.dat_o, 32'd0);
    chk("rst_strobes", 32'({ins_ack, ins_err, mem_ack, mem_err}), 32'd0);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    force_delay = 1;
    ins_txn(30'h100);
    mem_txn(32'h0000_0403, 1'b1, 8'hA5);
    mem_txn(32'h0000_0802, 1'b0, 8'h00);
    force_delay = 0;
    mem_txn(32'h0000_0801, 1'b0, 8'h00);
    force_delay = 15;
    ins_txn(30'h0ABC);
    mem_txn(32'hFC00_0010, 1'b0, 8'h00);
    ins_txn(30'h3F00_0001);
    force_delay = -1;
    max_delay = 15;
    fork
      ins_rand(25);
      mem_rand(25);
    join
    mem_en = 1'b1;
    mem_addr = 32'hFC00_0400;
    mem_we = 1'b1;
    mem_data_i = 8'h5A;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    chk("pre_reset_cyc", 32'(wb.cyc_o), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_cyc", 32'(wb.cyc_o), 32'd0);
    chk("async_rst_stb", 32'(wb.stb_o), 32'd0);
    chk("async_rst_sel", 32'(wb.sel_o), 32'd0);
    chk("async_rst_we", 32'(wb.we_o), 32'd0);
    chk("async_rst_strobes", 32'({mem_ack, mem_err}), 32'd0);
    mem_en = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    force_delay = 0;
    last_cyc = -1;
    order_q = '{1, 0, 1, 0, 1, 0};
    chk_order = 1'b1;
    fork
      for (int i = 0; i < 3; i++) ins_txn(30'h40 + 30'(i));
      for (int j = 0; j < 3; j++) mem_txn(32'h0000_0200 + 32'(j), 1'b0, 8'h00);
    join
    chk_order = 1'b0;
    chk("grant_order_all_seen", 32'(order_q.size()), 32'd0);
    chk("ins_queue_drained", 32'(ins_q.size()), 32'd0);
    chk("mem_queue_drained", 32'(mem_q.size()), 32'd0);
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Shares the CPU's single Wishbone B4 classic master port between two requesters: instruction fetch (32-bit word reads) and the load/store unit (8-bit byte reads/writes). Sits between `fetch`/memory stage and the bus. Owns bus-cycle sequencing, round-robin arbitration, byte-lane steering and a no-ack timeout that fails a hung cycle back to its requester.

## Interface
- TIMEOUT, 16, cycles a granted bus cycle may wait for `ack_i` before abort; 0 disables timeout
- cpu_clk  in  1  sole clock; Wishbone side also runs on it
- cpu_rst  in  1  reset, asynchronous, active-low
- ins_en  in  1  fetch request, held until `ins_ack` or `ins_err`
- ins_addr  in  30  word address of fetch
- ins_stl  out  1  fetch pending, not yet completed
- ins_ack  out  1  fetch completion strobe
- ins_err  out  1  fetch timed out
- ins_data  out  32  fetched word, valid with `ins_ack`
- mem_en  in  1  data request, held until `mem_ack` or `mem_err`
- mem_addr  in  32  byte address
- mem_we  in  1  1 = store, 0 = load
- mem_data_i  in  8  store byte
- mem_stl  out  1  data access pending
- mem_ack  out  1  data completion strobe
- mem_err  out  1  data access timed out
- mem_data_o  out  8  load byte, valid with `mem_ack`
- dat_i  in  32  Wishbone read data
- ack_i  in  1  Wishbone acknowledge
- dat_o  out  32  Wishbone write data
- adr_o  out  30  Wishbone word address
- cyc_o, stb_o  out  1 each  Wishbone cycle/strobe
- sel_o  out  4  byte select
- we_o  out  1  write enable

## Operation
- States: IDLE, BUS_INS, BUS_MEM.
- IDLE: if exactly one of `ins_en`/`mem_en` high, grant it; if both, grant the one not granted last (`last_grant` flag, reset value INS, so MEM wins first tie). Neither: stay.
- On grant, register bus outputs: `cyc_o=stb_o=1`.
  - INS: `adr_o=ins_addr`, `sel_o=4'hF`, `we_o=0`, `dat_o=0`.
  - MEM: `adr_o=mem_addr[31:2]`, `sel_o=4'b0001<<mem_addr[1:0]`, `we_o=mem_we`, `dat_o={4{mem_data_i}}`.
- Requester inputs sampled only at grant; changes while stalled are ignored until next grant.
- BUS_x: on `ack_i`, `x_ack=1` combinationally that cycle; `ins_data=dat_i`; `mem_data_o=dat_i[8*mem_addr_q[1:0]+:8]` (lane latched at grant). Next edge: cyc/stb/we/sel to 0, state IDLE, `last_grant` updated.
- Timeout: counter cleared at grant, increments each BUS cycle without ack; when counter == TIMEOUT-1 and no `ack_i`, `x_err=1` that cycle, bus dropped next edge, state IDLE. `ack_i` and timeout same cycle: ack wins, no err.
- `ins_stl = ins_en & ~ins_ack & ~ins_err`; same for mem.
- `ack_i` in IDLE ignored.

## Timing
- Reset (async assert): state IDLE, cyc_o/stb_o/we_o 0, sel_o 0, adr_o 0, dat_o 0, counter 0, last_grant INS; all ack/err 0. Mid-cycle reset drops cyc_o immediately; no ack/err issued.
- Request at cycle 0 (IDLE) → cyc_o high cycle 1 → zero-wait ack in cycle 1 → `x_ack` cycle 1 → IDLE cycle 2 → next grant cycle 3 earliest. Minimum 2 cycles per transaction.
- Timeout: err asserted in cycle TIMEOUT after grant-edge; cyc_o low following cycle.
- ack/err are single-cycle; requester drops or re-presents `en` at next edge.

## Structure
- `cpu_pkg`: `arb_state_t` enum (IDLE, BUS_INS, BUS_MEM), `grant_t` (GNT_INS, GNT_MEM), `WB_SEL_ALL` constant.
- Sub-module `wb_lane`: combinational byte-lane steering (sel generation, write replication, read extraction) from 2-bit lane index.
- Counter width `$clog2(TIMEOUT+1)`, minimum 1.

## Test plan
- Fetch alone: ins_en, ins_addr=30'h100, ack_i one cycle after cyc_o, dat_i=32'hDEADBEEF → adr_o=30'h100, sel_o=F, we_o=0, ins_ack pulse with ins_data=DEADBEEF, ins_stl low after.
- Byte store: mem_addr=32'h0000_0403, mem_we=1, mem_data_i=8'hA5 → adr_o=30'h100, sel_o=4'b1000, dat_o=A5A5A5A5, we_o=1, mem_ack on ack.
- Byte load lane 2: mem_addr=…02, dat_i=32'h11223344 → mem_data_o=8'h22.
- Both requesting continuously, zero-wait ack → grants alternate MEM, INS, MEM, INS; each 2 cycles.
- No ack, TIMEOUT=16 → exactly one err pulse 16 cycles after grant, cyc_o low next cycle; ack_i on that same cycle instead → ack, no err.
- cpu_rst asserted low mid BUS_MEM → cyc_o/stb_o drop asynchronously, no mem_ack; after release, tie goes to MEM.
